toggle_port_responder: RTL and testbench
========================================

TOGGLE_PORT_RESPONDER -- requirements
Module: toggle_port_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter ADDR_W, default 23, SHALL set the word address width.
REQ-003 Parameter MEM_LAT, default 2, SHALL set the memory read latency in clocks; the legal range is 1..15.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  system clock.
- init_n  in  1  asynchronous active-low reset.
- port1_req  in  1  request toggle from initiator 1.
- port1_ack  out  1  acknowledge toggle to initiator 1.
- port1_a  in  ADDR_W  word address.
- port1_ds  in  2  byte strobes {hi, lo}.
- port1_we  in  1  1 = write, 0 = read.
- port1_d  in  16  write data.
- port1_q  out  16  read data.
- port2_req, port2_ack, port2_a, port2_ds, port2_we, port2_d, port2_q  same as port 1, for initiator 2.
- mem_req  out  1  command valid.
- mem_busy  in  1  memory cannot accept a command this cycle.
- mem_we, mem_a, mem_ds, mem_d  out  1/ADDR_W/2/16  command fields.
- mem_q  in  16  read data, valid MEM_LAT clocks after acceptance.

Function
REQ-005 Port n SHALL be pending when portn_req != portn_ack, sampled on clk.
REQ-006 The FSM SHALL have the states IDLE, ISSUE and WAIT.
REQ-007 In IDLE with one port pending, the block SHALL latch that port's a/ds/we/d and go to ISSUE on the same edge (the detection edge).
REQ-008 In IDLE with both ports pending, the block SHALL serve the port not served last (round-robin).
REQ-009 The last-served flag SHALL reset to port 2, so port 1 wins the first tie.
REQ-010 In ISSUE, mem_req SHALL be 1 and the mem_* fields SHALL equal the latched values.
REQ-011 The command SHALL be accepted on the first edge where mem_busy=0; while mem_busy=1 the block SHALL stay in ISSUE with all fields stable.
REQ-012 On the acceptance edge the block SHALL go to WAIT and load a counter with MEM_LAT-1; mem_req SHALL be 0 outside ISSUE.
REQ-013 In WAIT the counter SHALL decrement each edge.
REQ-014 On the edge where the counter is 0, the block SHALL do all of the following:
- toggle the served portn_ack;
- for a read, load portn_q from mem_q; for a write, leave portn_q unchanged;
- update the last-served flag;
- return to IDLE.
REQ-015 With mem_busy=0, ack SHALL toggle exactly MEM_LAT+1 edges after the detection edge.
REQ-016 A port may be detected on the edge after its own ack toggle, with no dead cycle beyond IDLE.
REQ-017 Changes to portn_a/ds/we/d after the detection edge SHALL have no effect on the request in flight.
REQ-018 A second req toggle before ack is a protocol violation; req!=ack SHALL be the only pending criterion, with no extra recovery logic.
REQ-019 A command with ds=00 SHALL be issued unchanged to memory.
REQ-020 Unserved pending requests SHALL remain pending without limit; no timeout.

Reset
REQ-021 While init_n=0, outputs SHALL be: port1_ack=0, port2_ack=0, port1_q=0, port2_q=0, mem_req=0, mem_we=0, mem_a=0, mem_ds=0, mem_d=0.
REQ-022 While init_n=0, the FSM SHALL be in IDLE, the counter SHALL be 0 and the last-served flag SHALL be port 2.
REQ-023 Reset asserted mid-transaction SHALL abort the transaction: no ack toggle, and mem_req falls to 0 asynchronously.
REQ-024 Initiators SHALL hold req=0 across reset; the first cycle after release SHALL see no pending request.

Configuration
REQ-025 With macro TPR_PORT2_EN defined, both ports and round-robin arbitration SHALL be compiled in.
REQ-026 Without TPR_PORT2_EN:
- port2 inputs SHALL be ignored;
- port2_ack and port2_q SHALL be constant 0;
- only port 1 is ever served;
- timing of port 1 SHALL be identical to REQ-015.

Verification
REQ-027 Single read: MEM_LAT=2, mem_busy=0, port1 read a=0x1234, mem_q=0xBEEF -> mem_req high for 1 clock with mem_a=0x1234, port1_ack toggles 3 edges after detection, port1_q=0xBEEF.
REQ-028 Write: port2 write d=0xA55A, ds=01 -> mem_we=1, mem_d=0xA55A, mem_ds=01, port2_ack toggles, port2_q unchanged.
REQ-029 Busy stall: mem_busy=1 for 4 clocks during ISSUE -> mem_req and fields held for 5 clocks, ack delayed by exactly 4 edges.
REQ-030 Simultaneous requests from reset: port1 served first, then port2; repeated ties alternate 1,2,1,2 over 4 transactions.
REQ-031 Reset mid-WAIT: init_n=0 two edges after acceptance -> all outputs 0 immediately, no ack toggle after release.
REQ-032 Macro off: toggle port2_req -> port2_ack stays 0 and no mem_req occurs; port 1 traffic behaves as in REQ-027.

Source files
------------

// File: rtl/toggle_port_responder.sv
// toggle_port_responder: toggle-handshake front end that arbitrates up to two
// initiators onto a single fixed-latency 16-bit word memory.
// Optional feature macro: TPR_PORT2_EN (port 2 and round-robin arbitration).
module toggle_port_responder #(
    parameter int unsigned ADDR_W  = 23,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              init_n,
    input  logic              port1_req,
    output logic              port1_ack,
    input  logic [ADDR_W-1:0] port1_a,
    input  logic [1:0]        port1_ds,
    input  logic              port1_we,
    input  logic [15:0]       port1_d,
    output logic [15:0]       port1_q,
    input  logic              port2_req,
    output logic              port2_ack,
    input  logic [ADDR_W-1:0] port2_a,
    input  logic [1:0]        port2_ds,
    input  logic              port2_we,
    input  logic [15:0]       port2_d,
    output logic [15:0]       port2_q,
    output logic              mem_req,
    input  logic              mem_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [1:0]        mem_ds,
    output logic [15:0]       mem_d,
    input  logic [15:0]       mem_q
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DS_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_q, last_d;     // 1 = port 2 was served last
    logic                sel_q, sel_d;       // 1 = port 2 owns the request in flight
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   a_q, a_d;
    logic [DS_W-1:0]     ds_q, ds_d;
    logic [DATA_W-1:0]   d_q, d_d;
    logic                p1_ack_q, p1_ack_d;
    logic                p2_ack_q, p2_ack_d;
    logic [DATA_W-1:0]   p1_rd_q, p1_rd_d;
    logic [DATA_W-1:0]   p2_rd_q, p2_rd_d;
    logic                mem_req_q, mem_req_d;

    logic                p1_pend_c;
    logic                p2_pend_c;
    logic                pick2_c;
    logic                sel_we_c;
    logic [ADDR_W-1:0]   sel_a_c;
    logic [DS_W-1:0]     sel_ds_c;
    logic [DATA_W-1:0]   sel_d_c;

    // Pending detection and request selection
    assign p1_pend_c = (port1_req != p1_ack_q);

`ifdef TPR_PORT2_EN
    assign p2_pend_c = (port2_req != p2_ack_q);
    // On a tie, serve whichever port did not go last
    assign pick2_c   = p2_pend_c && (!p1_pend_c || !last_q);
    assign sel_we_c  = pick2_c ? port2_we : port1_we;
    assign sel_a_c   = pick2_c ? port2_a  : port1_a;
    assign sel_ds_c  = pick2_c ? port2_ds : port1_ds;
    assign sel_d_c   = pick2_c ? port2_d  : port1_d;
`else
    logic unused_c;
    assign p2_pend_c = 1'b0;
    assign pick2_c   = 1'b0;
    assign sel_we_c  = port1_we;
    assign sel_a_c   = port1_a;
    assign sel_ds_c  = port1_ds;
    assign sel_d_c   = port1_d;
    // Port 2 is not built; its inputs and the arbitration flag go nowhere
    assign unused_c  = ^{port2_req, port2_a, port2_ds, port2_we, port2_d, last_q};
`endif

    // State register and all registered outputs
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            sel_q     <= 1'b0;
            we_q      <= 1'b0;
            a_q       <= '0;
            ds_q      <= '0;
            d_q       <= '0;
            p1_ack_q  <= 1'b0;
            p2_ack_q  <= 1'b0;
            p1_rd_q   <= '0;
            p2_rd_q   <= '0;
            mem_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            a_q       <= a_d;
            ds_q      <= ds_d;
            d_q       <= d_d;
            p1_ack_q  <= p1_ack_d;
            p2_ack_q  <= p2_ack_d;
            p1_rd_q   <= p1_rd_d;
            p2_rd_q   <= p2_rd_d;
            mem_req_q <= mem_req_d;
        end
    end

    // Next-state: latch on detection, issue until accepted, count out the latency
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        sel_d     = sel_q;
        we_d      = we_q;
        a_d       = a_q;
        ds_d      = ds_q;
        d_d       = d_q;
        p1_ack_d  = p1_ack_q;
        p2_ack_d  = p2_ack_q;
        p1_rd_d   = p1_rd_q;
        p2_rd_d   = p2_rd_q;
        mem_req_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (p1_pend_c || p2_pend_c) begin
                    sel_d   = pick2_c;
                    we_d    = sel_we_c;
                    a_d     = sel_a_c;
                    ds_d    = sel_ds_c;
                    d_d     = sel_d_c;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!mem_busy) begin
                    cnt_d   = CNT_W'(MEM_LAT - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (sel_q) begin
                        p2_ack_d = ~p2_ack_q;
                        if (!we_q) begin
                            p2_rd_d = mem_q;
                        end
                    end else begin
                        p1_ack_d = ~p1_ack_q;
                        if (!we_q) begin
                            p1_rd_d = mem_q;
                        end
                    end
                    last_d  = sel_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mem_req_d = (state_d == ST_ISSUE);
    end

    assign port1_ack = p1_ack_q;
    assign port1_q   = p1_rd_q;
    assign port2_ack = p2_ack_q;
    assign port2_q   = p2_rd_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = we_q;
    assign mem_a     = a_q;
    assign mem_ds    = ds_q;
    assign mem_d     = d_q;

endmodule

// File: tb/tb_toggle_port_responder.sv
// tb_toggle_port_responder: directed stimulus, memory responder, and a
// timestamp-based transaction model compared against the DUT every cycle.
// Honours TPR_PORT2_EN the same way the design does.
module tb_toggle_port_responder;

    localparam int ADDR_W  = 23;
    localparam int MEM_LAT = 2;
`ifdef TPR_PORT2_EN
    localparam bit P2_EN = 1'b1;
`else
    localparam bit P2_EN = 1'b0;
`endif

    logic              clk;
    logic              init_n;
    logic              port1_req, port1_ack, port1_we;
    logic [ADDR_W-1:0] port1_a;
    logic [1:0]        port1_ds;
    logic [15:0]       port1_d, port1_q;
    logic              port2_req, port2_ack, port2_we;
    logic [ADDR_W-1:0] port2_a;
    logic [1:0]        port2_ds;
    logic [15:0]       port2_d, port2_q;
    logic              mem_req, mem_busy, mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [1:0]        mem_ds;
    logic [15:0]       mem_d, mem_q;

    int n_tests = 0;
    int n_fail  = 0;

    toggle_port_responder #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .init_n(init_n),
        .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
        .port1_ds(port1_ds), .port1_we(port1_we), .port1_d(port1_d), .port1_q(port1_q),
        .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
        .port2_ds(port2_ds), .port2_we(port2_we), .port2_d(port2_d), .port2_q(port2_q),
        .mem_req(mem_req), .mem_busy(mem_busy), .mem_we(mem_we), .mem_a(mem_a),
        .mem_ds(mem_ds), .mem_d(mem_d), .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: one pinned word, everything else derived from the address
    function automatic logic [15:0] mem_val(input logic [ADDR_W-1:0] a);
        if (a == 23'h001234) return 16'hBEEF;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    // Memory: data appears only in the cycle ahead of edge acceptance+MEM_LAT
    initial begin : memory
        int rem;
        logic [ADDR_W-1:0] addr;
        rem   = 0;
        addr  = '0;
        mem_q = 16'hDEAD;
        forever begin
            @(negedge clk); #2;
            if (mem_req && !mem_busy) begin
                rem  = MEM_LAT;
                addr = mem_a;
            end
            @(posedge clk); #2;
            if (rem > 0) begin
                rem--;
                mem_q = (rem == 0) ? mem_val(addr) : 16'hDEAD;
            end else begin
                mem_q = 16'hDEAD;
            end
        end
    end

    // Transaction model: absolute edge timestamps, compared 1 time unit after every edge
    initial begin : model
        int cyc, acc, port, last;
        bit act, p1, p2, e_req;
        logic s_init, s_busy;
        logic m_we;
        logic [ADDR_W-1:0] m_a;
        logic [1:0] m_ds;
        logic [15:0] m_d;
        logic e_ack1, e_ack2;
        logic [15:0] e_q1, e_q2;
        cyc = 0; acc = -1; port = 1; last = 2; act = 0;
        m_we = 0; m_a = '0; m_ds = '0; m_d = '0;
        e_ack1 = 0; e_ack2 = 0; e_q1 = '0; e_q2 = '0;
        forever begin
            @(posedge clk);
            cyc++;
            s_init = init_n;
            s_busy = mem_busy;
            if (!s_init) begin
                act = 0; acc = -1; last = 2;
                e_ack1 = 0; e_ack2 = 0; e_q1 = '0; e_q2 = '0;
                m_we = 0; m_a = '0; m_ds = '0; m_d = '0;
            end else if (act) begin
                if (acc < 0) begin
                    if (!s_busy) acc = cyc;
                end else if (cyc == acc + MEM_LAT) begin
                    if (port == 1) begin
                        e_ack1 = ~e_ack1;
                        if (!m_we) e_q1 = mem_val(m_a);
                    end else begin
                        e_ack2 = ~e_ack2;
                        if (!m_we) e_q2 = mem_val(m_a);
                    end
                    last = port;
                    act  = 0;
                end
            end else begin
                p1 = (port1_req != e_ack1);
                p2 = P2_EN && (port2_req != e_ack2);
                if (p1 || p2) begin
                    port = (p1 && p2) ? (3 - last) : (p1 ? 1 : 2);
                    if (port == 1) begin
                        m_we = port1_we; m_a = port1_a; m_ds = port1_ds; m_d = port1_d;
                    end else begin
                        m_we = port2_we; m_a = port2_a; m_ds = port2_ds; m_d = port2_d;
                    end
                    act = 1;
                    acc = -1;
                end
            end
            e_req = act && (acc < 0);
            #1;
            check("cyc_mem_req", 32'(mem_req), 32'(e_req));
            check("cyc_port1_ack", 32'(port1_ack), 32'(e_ack1));
            check("cyc_port2_ack", 32'(port2_ack), 32'(e_ack2));
            check("cyc_port1_q", 32'(port1_q), 32'(e_q1));
            check("cyc_port2_q", 32'(port2_q), 32'(e_q2));
            if (e_req || !s_init) begin
                check("cyc_mem_we", 32'(mem_we), 32'(m_we));
                check("cyc_mem_a", 32'(mem_a), 32'(m_a));
                check("cyc_mem_ds", 32'(mem_ds), 32'(m_ds));
                check("cyc_mem_d", 32'(mem_d), 32'(m_d));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no end of test, expected completion before 100000");
        $fatal(1, "watchdog expired");
    end

    // Results of the latest xact() call
    int                lat_r, reqc_r;
    logic              seen_we_r;
    logic [ADDR_W-1:0] seen_a_r;
    logic [1:0]        seen_ds_r;
    logic [15:0]       seen_d_r;

    task automatic chk_zero(input string tag);
        check({tag, "_port1_ack"}, 32'(port1_ack), 32'd0);
        check({tag, "_port2_ack"}, 32'(port2_ack), 32'd0);
        check({tag, "_port1_q"},   32'(port1_q),   32'd0);
        check({tag, "_port2_q"},   32'(port2_q),   32'd0);
        check({tag, "_mem_req"},   32'(mem_req),   32'd0);
        check({tag, "_mem_we"},    32'(mem_we),    32'd0);
        check({tag, "_mem_a"},     32'(mem_a),     32'd0);
        check({tag, "_mem_ds"},    32'(mem_ds),    32'd0);
        check({tag, "_mem_d"},     32'(mem_d),     32'd0);
    endtask

    // One request on port p; lat_r-1 = edges from detection to the ack toggle
    task automatic xact(input int p, input logic we, input logic [ADDR_W-1:0] a,
                        input logic [1:0] ds, input logic [15:0] d,
                        input int busy_n, input bit scramble);
        bit done;
        @(negedge clk);
        if (p == 1) begin
            port1_we = we; port1_a = a; port1_ds = ds; port1_d = d; port1_req = ~port1_req;
        end else begin
            port2_we = we; port2_a = a; port2_ds = ds; port2_d = d; port2_req = ~port2_req;
        end
        mem_busy = (busy_n > 0);
        lat_r = 0; reqc_r = 0; done = 0;
        seen_we_r = 0; seen_a_r = '0; seen_ds_r = '0; seen_d_r = '0;
        while (!done && lat_r < 100) begin
            @(posedge clk); #1;
            lat_r++;
            if (mem_req) begin
                reqc_r++;
                seen_we_r = mem_we; seen_a_r = mem_a; seen_ds_r = mem_ds; seen_d_r = mem_d;
            end
            done = (p == 1) ? (port1_ack == port1_req) : (port2_ack == port2_req);
            if (!done) begin
                @(negedge clk);
                if (lat_r == busy_n + 1) mem_busy = 1'b0;
                if (scramble && lat_r == 1) begin
                    if (p == 1) begin
                        port1_a = ~port1_a; port1_d = ~port1_d; port1_we = ~port1_we; port1_ds = ~port1_ds;
                    end else begin
                        port2_a = ~port2_a; port2_d = ~port2_d; port2_we = ~port2_we; port2_ds = ~port2_ds;
                    end
                end
            end
        end
        mem_busy = 1'b0;
        check("xact_ack_seen", 32'(done), 32'd1);
    endtask

    // Start a port-1 read, then assert reset after `edges` clock edges
    task automatic reset_abort(input string tag, input logic [ADDR_W-1:0] a,
                               input bit busy, input int edges);
        int cnt;
        @(negedge clk);
        port1_we = 1'b0; port1_a = a; port1_ds = 2'b11; port1_req = ~port1_req;
        mem_busy = busy;
        repeat (edges) @(posedge clk);
        @(negedge clk);
        init_n = 1'b0; port1_req = 1'b0; port2_req = 1'b0; mem_busy = 1'b0;
        #1;
        chk_zero(tag);
        repeat (2) @(negedge clk);
        init_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (mem_req || port1_ack || port2_ack) cnt++;
        end
        check({tag, "_quiet_after_release"}, 32'(cnt), 32'd0);
    endtask

`ifdef TPR_PORT2_EN
    // Both ports toggle together; order of ack toggles must be 1 then 2
    task automatic tie_round(input string tag);
        int order[$];
        int n;
        logic a1, a2;
        @(negedge clk);
        port1_we = 1'b0; port1_a = 23'h000011; port1_ds = 2'b11;
        port2_we = 1'b0; port2_a = 23'h000022; port2_ds = 2'b11;
        port1_req = ~port1_req; port2_req = ~port2_req;
        a1 = port1_ack; a2 = port2_ack; n = 0;
        while ((port1_ack != port1_req || port2_ack != port2_req) && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (port1_ack != a1) order.push_back(1);
            if (port2_ack != a2) order.push_back(2);
            a1 = port1_ack; a2 = port2_ack;
        end
        check({tag, "_count"}, 32'(order.size()), 32'd2);
        if (order.size() >= 2) begin
            check({tag, "_first"},  32'(order[0]), 32'd1);
            check({tag, "_second"}, 32'(order[1]), 32'd2);
        end
    endtask
`endif

    initial begin : stim
        init_n = 1'b0; mem_busy = 1'b0;
        port1_req = 0; port1_we = 0; port1_a = '0; port1_ds = '0; port1_d = '0;
        port2_req = 0; port2_we = 0; port2_a = '0; port2_ds = '0; port2_d = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        init_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("no_pending_after_release", 32'(mem_req), 32'd0);

        // Single read
        xact(1, 1'b0, 23'h001234, 2'b11, 16'h0000, 0, 0);
        check("rd_ack_edges", 32'(lat_r - 1), 32'd3);
        check("rd_req_cycles", 32'(reqc_r), 32'd1);
        check("rd_mem_a", 32'(seen_a_r), 32'h001234);
        check("rd_mem_we", 32'(seen_we_r), 32'd0);
        check("rd_port1_q", 32'(port1_q), 32'hBEEF);

        // Back-to-back read, detected on the edge after the previous ack
        xact(1, 1'b0, 23'h000042, 2'b11, 16'h0000, 0, 0);
        check("b2b_ack_edges", 32'(lat_r - 1), 32'd3);
        check("b2b_port1_q", 32'(port1_q), 32'h5A18);

        // Write at the top address: q untouched
        xact(1, 1'b1, 23'h7FFFFF, 2'b01, 16'h1357, 0, 0);
        check("wr_mem_we", 32'(seen_we_r), 32'd1);
        check("wr_mem_a", 32'(seen_a_r), 32'h7FFFFF);
        check("wr_mem_ds", 32'(seen_ds_r), 32'd1);
        check("wr_mem_d", 32'(seen_d_r), 32'h1357);
        check("wr_port1_q_kept", 32'(port1_q), 32'h5A18);

        // Empty byte strobes are still issued
        xact(1, 1'b1, 23'h000077, 2'b00, 16'hC3C3, 0, 0);
        check("ds0_mem_ds", 32'(seen_ds_r), 32'd0);
        check("ds0_mem_d", 32'(seen_d_r), 32'hC3C3);
        check("ds0_ack_edges", 32'(lat_r - 1), 32'd3);

        // Busy for 4 clocks in ISSUE
        xact(1, 1'b0, 23'h000100, 2'b11, 16'h0000, 4, 0);
        check("busy_ack_edges", 32'(lat_r - 1), 32'd7);
        check("busy_req_cycles", 32'(reqc_r), 32'd5);
        check("busy_port1_q", 32'(port1_q), 32'h5B5A);

        // Inputs change after detection while the command is stalled
        xact(1, 1'b0, 23'h000200, 2'b11, 16'h0000, 2, 1);
        check("scr_mem_a", 32'(seen_a_r), 32'h000200);
        check("scr_mem_we", 32'(seen_we_r), 32'd0);
        check("scr_req_cycles", 32'(reqc_r), 32'd3);
        check("scr_ack_edges", 32'(lat_r - 1), 32'd5);
        check("scr_port1_q", 32'(port1_q), 32'h585A);

`ifdef TPR_PORT2_EN
        xact(2, 1'b0, 23'h000042, 2'b11, 16'h0000, 0, 0);
        check("p2_rd_port2_q", 32'(port2_q), 32'h5A18);
        xact(2, 1'b1, 23'h000AAA, 2'b01, 16'hA55A, 0, 0);
        check("p2_wr_mem_we", 32'(seen_we_r), 32'd1);
        check("p2_wr_mem_d", 32'(seen_d_r), 32'hA55A);
        check("p2_wr_mem_ds", 32'(seen_ds_r), 32'd1);
        check("p2_wr_port2_q_kept", 32'(port2_q), 32'h5A18);
        check("p2_wr_ack_edges", 32'(lat_r - 1), 32'd3);
`else
        begin : p2_off
            int cnt;
            @(negedge clk);
            port2_we = 1'b0; port2_a = 23'h000055; port2_ds = 2'b11; port2_req = ~port2_req;
            cnt = 0;
            repeat (10) begin
                @(posedge clk); #1;
                if (mem_req) cnt++;
            end
            check("p2_off_mem_req", 32'(cnt), 32'd0);
            check("p2_off_port2_ack", 32'(port2_ack), 32'd0);
            check("p2_off_port2_q", 32'(port2_q), 32'd0);
        end
        xact(1, 1'b0, 23'h001234, 2'b11, 16'h0000, 0, 0);
        check("p2_off_p1_ack_edges", 32'(lat_r - 1), 32'd3);
        check("p2_off_p1_q", 32'(port1_q), 32'hBEEF);
`endif

        reset_abort("rst_wait", 23'h000300, 1'b0, 3);
        reset_abort("rst_issue", 23'h000301, 1'b1, 2);

`ifdef TPR_PORT2_EN
        tie_round("tie_a");
        tie_round("tie_b");
`endif

        // Normal service after the aborted transactions
        xact(1, 1'b0, 23'h000042, 2'b11, 16'h0000, 0, 0);
        check("post_rst_ack_edges", 32'(lat_r - 1), 32'd3);
        check("post_rst_port1_q", 32'(port1_q), 32'h5A18);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
